tdm_mux4: RTL and testbench

//  4-to-1 time-division multiplexer: the transmit end of the 4-way select-coded channel link.

---
 rtl/tdm_mux_pkg.sv | 29 ++
 rtl/rr_arbiter4.sv | 31 +++
 rtl/tdm_mux4.sv | 123 ++++++++++++
 tb/tb_tdm_mux4.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared constants, FSM state type and select-pair helpers for the 4-way TDM link.
package tdm_mux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic s1;
    logic s0;
  } sel_t;

  // Channel number is {s0,s1}, so s0 carries the high bit of the channel.
  function automatic sel_t ch_to_sel(input logic [CH_W-1:0] ch);
    sel_t sel;
    sel.s1 = ch[0];
    sel.s0 = ch[1];
    return sel;
  endfunction

  function automatic logic [CH_W-1:0] sel_to_ch(input sel_t sel);
    return {sel.s0, sel.s1};
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-request round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter4
  import tdm_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any
);

  logic [CH_W-1:0] idx;

  // Scan ptr, ptr+1, ... with natural 2-bit wrap; the first hit locks out later ones.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = ptr + CH_W'(i);
      if (en && !any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_mux4.sv
// 4:1 round-robin TDM multiplexer with optional packet-atomic grants and a
// registered output lane carrying the source channel as an (s1,s0) select pair.
module tdm_mux4
  import tdm_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          PKT_MODE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH-1:0]         in_last,
  output logic [NUM_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_s0,
  output logic                      out_s1,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   owner_q;

  logic              load_en_c;
  logic              arb_en_c;
  logic [NUM_CH-1:0] arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;

  logic [NUM_CH-1:0] gnt_c;
  logic [CH_W-1:0]   gnt_idx_c;
  logic              accept_c;
  sel_t              gnt_sel_c;

  logic [WIDTH-1:0]  ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // A beat may load whenever the output register is empty or draining this edge.
  assign load_en_c = !out_valid || out_ready;
  assign arb_en_c  = load_en_c && (state_q == ARB) && !rst;

  rr_arbiter4 u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .en      (arb_en_c),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and grant: free arbitration in ARB, owner-only service in LOCKED.
  always_comb begin
    state_d   = state_q;
    gnt_c     = '0;
    gnt_idx_c = arb_idx;
    accept_c  = 1'b0;
    case (state_q)
      ARB: begin
        if (arb_any) begin
          gnt_c    = arb_gnt;
          accept_c = 1'b1;
          if (PKT_MODE && !in_last[arb_idx]) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        gnt_idx_c = owner_q;
        if (load_en_c && in_valid[owner_q] && !rst) begin
          gnt_c[owner_q] = 1'b1;
          accept_c       = 1'b1;
          if (in_last[owner_q]) begin
            state_d = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign in_ready  = gnt_c;
  assign gnt_sel_c = ch_to_sel(gnt_idx_c);

  // Output beat register; a new accept overwrites a draining beat with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_s0    <= 1'b0;
      out_s1    <= 1'b0;
      out_last  <= 1'b0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[gnt_idx_c];
      out_s0    <= gnt_sel_c.s0;
      out_s1    <= gnt_sel_c.s1;
      out_last  <= in_last[gnt_idx_c];
      rr_ptr_q  <= gnt_idx_c + CH_W'(1);
      if (state_q == ARB) begin
        owner_q <= gnt_idx_c;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_mux4.sv
// Bench for tdm_mux4: cycle-by-cycle behavioural model plus directed literal checks.
module tb_tdm_mux4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_s0, out_s1, out_last, out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  tdm_mux4 #(.WIDTH(8), .PKT_MODE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_s0    (out_s0),
    .out_s1    (out_s1),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int grant_of(input logic [3:0] r);
    int g;
    g = -1;
    for (int k = 0; k < 4; k++) if (r[k]) g = k;
    return g;
  endfunction

  // Model: the beat sitting on the lane, the round-robin start point, and the packet owner.
  bit         m_ok = 1'b0;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  bit         m_last;
  int         m_ptr;
  int         m_owner;
  int         m_g;
  logic [3:0] m_ready;

  always @(negedge clk) begin
    m_g = -1;
    if (!rst && (!m_valid || out_ready)) begin
      if (m_owner >= 0) begin
        if (in_valid[m_owner]) m_g = m_owner;
      end else begin
        for (int k = 0; k < 4; k++)
          if (m_g < 0 && in_valid[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
      end
    end
    m_ready = 4'b0000;
    if (m_g >= 0) m_ready[m_g] = 1'b1;

    if (m_ok) begin
      chk("model in_ready", 32'(in_ready), 32'(m_ready));
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      chk("model out_data", 32'(out_data), 32'(m_data));
      chk("model out_s0", 32'(out_s0), 32'(m_ch >= 2));
      chk("model out_s1", 32'(out_s1), 32'(m_ch % 2));
      chk("model out_last", 32'(out_last), 32'(m_last));
    end

    if (rst) begin
      m_ok = 1'b1; m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_last = 1'b0;
      m_ptr = 0; m_owner = -1;
    end else if (m_g >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[m_g*8 +: 8];
      m_ch    = m_g;
      m_last  = in_last[m_g];
      m_ptr   = (m_g + 1) % 4;
      m_owner = in_last[m_g] ? -1 : m_g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int gseq[5];
  logic [7:0] held;

  initial begin
    rst = 1'b1; in_data = 32'h0; in_valid = 4'b0000; in_last = 4'b1111; out_ready = 1'b1;

    // Reset with every source requesting.
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    #1;
    chk("reset in_ready", 32'(in_ready), 32'h0);
    tick(); tick();
    chk("reset in_ready held", 32'(in_ready), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_data", 32'(out_data), 32'h0);
    chk("reset sel", 32'({out_s0, out_s1, out_last}), 32'h0);

    // Single source on ch2.
    rst = 1'b0; in_valid = 4'b0100; in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    #1;
    chk("single in_ready", 32'(in_ready), 32'h4);
    tick();
    in_valid = 4'b0000;
    chk("single out_data", 32'(out_data), 32'hA5);
    chk("single s0s1", 32'({out_s0, out_s1}), 32'b10);
    chk("single out_valid", 32'(out_valid), 32'h1);
    tick();

    // Round-robin from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 4'b1111; in_last = 4'b1111; in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int b = 0; b < 5; b++) begin
      #1;
      gseq[b] = grant_of(in_ready);
      tick();
    end
    in_valid = 4'b0000;
    chk("rr grant0", 32'(gseq[0]), 32'd0);
    chk("rr grant1", 32'(gseq[1]), 32'd1);
    chk("rr grant2", 32'(gseq[2]), 32'd2);
    chk("rr grant3", 32'(gseq[3]), 32'd3);
    chk("rr grant4", 32'(gseq[4]), 32'd0);
    tick();

    // Packet lock on ch1 with ch0 and ch3 competing; pointer sits at 1.
    in_valid = 4'b1011;
    for (int b = 0; b < 3; b++) begin
      in_data[15:8] = 8'(8'h21 + b);
      in_last = {1'b1, 1'b1, (b == 2), 1'b1};
      #1;
      gseq[b] = grant_of(in_ready);
      tick();
    end
    #1;
    gseq[3] = grant_of(in_ready);
    tick();
    in_valid = 4'b0000; in_last = 4'b1111;
    chk("pkt beat1", 32'(gseq[0]), 32'd1);
    chk("pkt beat2", 32'(gseq[1]), 32'd1);
    chk("pkt beat3", 32'(gseq[2]), 32'd1);
    chk("pkt after", 32'(gseq[3]), 32'd3);
    tick();

    // Backpressure with a beat held and ch1 waiting.
    in_valid = 4'b0001; in_data = {8'h13, 8'h12, 8'h5B, 8'h3C};
    tick();
    out_ready = 1'b0; in_valid = 4'b0010;
    held = out_data;
    chk("bp held data", 32'(held), 32'h3C);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp stable data", 32'(out_data), 32'(held));
      chk("bp stable valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'h2);
    tick();
    in_valid = 4'b0000;
    chk("bp next data", 32'(out_data), 32'h5B);
    chk("bp next valid", 32'(out_valid), 32'h1);
    tick();

    // Reset in the middle of a ch1 packet.
    in_valid = 4'b0010; in_last = 4'b1101;
    tick(); tick();
    in_valid = 4'b0011; rst = 1'b1;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    #1;
    chk("midrst first grant", 32'(grant_of(in_ready)), 32'd0);
    tick();
    in_valid = 4'b0000;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
